// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side inputs, execute-side outputs and hazard controls.
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // Decode-stage control and data
    logic             regWriteD, memWriteD, memReadD, ALUSrcD, branchD, jumpD;
    logic [1:0]       resultSrcD, ALUOpD, immSrcD;
    logic [2:0]       funct3D;
    logic             funct7b5D;
    logic [XLEN-1:0]  rd1D, rd2D, immExtD, pcD, pcPlus4D;
    logic [4:0]       rs1D, rs2D, rdD;
    logic             validD;
    logic             pcSrcE;

    // Execute-stage registered copies
    logic             regWriteE, memWriteE, memReadE, ALUSrcE, branchE, jumpE;
    logic [1:0]       resultSrcE, ALUOpE;
    logic [2:0]       funct3E;
    logic             funct7b5E;
    logic [XLEN-1:0]  rd1E, rd2E, immExtE, pcE, pcPlus4E;
    logic [4:0]       rs1E, rs2E, rdE;
    logic             validE;

    // Hazard controls and debug counter
    logic             stallF, stallD, flushD;
    logic [CNT_W-1:0] bubbleCount;

    // Upstream side: drives decode fields and the EX branch decision
    modport master (
        output regWriteD, memWriteD, memReadD, ALUSrcD, branchD, jumpD,
               resultSrcD, ALUOpD, immSrcD, funct3D, funct7b5D,
               rd1D, rd2D, immExtD, pcD, pcPlus4D, rs1D, rs2D, rdD, validD, pcSrcE,
        input  regWriteE, memWriteE, memReadE, ALUSrcE, branchE, jumpE,
               resultSrcE, ALUOpE, funct3E, funct7b5E,
               rd1E, rd2E, immExtE, pcE, pcPlus4E, rs1E, rs2E, rdE, validE,
               stallF, stallD, flushD, bubbleCount
    );

    // Pipeline register side
    modport slave (
        input  regWriteD, memWriteD, memReadD, ALUSrcD, branchD, jumpD,
               resultSrcD, ALUOpD, immSrcD, funct3D, funct7b5D,
               rd1D, rd2D, immExtD, pcD, pcPlus4D, rs1D, rs2D, rdD, validD, pcSrcE,
        output regWriteE, memWriteE, memReadE, ALUSrcE, branchE, jumpE,
               resultSrcE, ALUOpE, funct3E, funct7b5E,
               rd1E, rd2E, immExtE, pcE, pcPlus4E, rs1E, rs2E, rdE, validE,
               stallF, stallD, flushD, bubbleCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/bubble
// insertion and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic            regWrite;
        logic            memWrite;
        logic            memRead;
        logic            ALUSrc;
        logic            branch;
        logic            jump;
        logic [1:0]      resultSrc;
        logic [1:0]      ALUOp;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] immExt;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            valid;
    } ex_word_t;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ex_word_t         w_d_p0;
    ex_word_t         r_ex_p1;
    logic [CNT_W-1:0] r_bubbleCount_p1;
    logic             w_lwStall;
    logic             w_flushE;

    // Gather the decode-side word; immSrcD is consumed in decode and not carried
    always_comb begin
        w_d_p0           = '0;
        w_d_p0.regWrite  = bus.regWriteD;
        w_d_p0.memWrite  = bus.memWriteD;
        w_d_p0.memRead   = bus.memReadD;
        w_d_p0.ALUSrc    = bus.ALUSrcD;
        w_d_p0.branch    = bus.branchD;
        w_d_p0.jump      = bus.jumpD;
        w_d_p0.resultSrc = bus.resultSrcD;
        w_d_p0.ALUOp     = bus.ALUOpD;
        w_d_p0.funct3    = bus.funct3D;
        w_d_p0.funct7b5  = bus.funct7b5D;
        w_d_p0.rd1       = bus.rd1D;
        w_d_p0.rd2       = bus.rd2D;
        w_d_p0.immExt    = bus.immExtD;
        w_d_p0.pc        = bus.pcD;
        w_d_p0.pcPlus4   = bus.pcPlus4D;
        w_d_p0.rs1       = bus.rs1D;
        w_d_p0.rs2       = bus.rs2D;
        w_d_p0.rd        = bus.rdD;
        w_d_p0.valid     = bus.validD;
    end

    // Load-use hazard: a load in EX whose nonzero rd feeds a D source operand.
    // A taken branch in EX overrides it, since D is being discarded anyway.
    always_comb begin
        w_lwStall = r_ex_p1.valid & r_ex_p1.memRead & ~bus.pcSrcE &
                    (r_ex_p1.rd != 5'd0) &
                    ((r_ex_p1.rd == bus.rs1D) | (r_ex_p1.rd == bus.rs2D));
        w_flushE  = w_lwStall | bus.pcSrcE;
    end

    // ID -> EX boundary: capture decode word or insert an all-zero bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_p1 <= '0;
        end else if (w_flushE) begin
            r_ex_p1 <= '0;
        end else begin
            r_ex_p1 <= w_d_p0;
        end
    end

    // Count bubbles that displaced a real instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubbleCount_p1 <= '0;
        end else if (w_flushE && bus.validD) begin
            r_bubbleCount_p1 <= sat_inc(r_bubbleCount_p1);
        end
    end

    assign bus.regWriteE   = r_ex_p1.regWrite;
    assign bus.memWriteE   = r_ex_p1.memWrite;
    assign bus.memReadE    = r_ex_p1.memRead;
    assign bus.ALUSrcE     = r_ex_p1.ALUSrc;
    assign bus.branchE     = r_ex_p1.branch;
    assign bus.jumpE       = r_ex_p1.jump;
    assign bus.resultSrcE  = r_ex_p1.resultSrc;
    assign bus.ALUOpE      = r_ex_p1.ALUOp;
    assign bus.funct3E     = r_ex_p1.funct3;
    assign bus.funct7b5E   = r_ex_p1.funct7b5;
    assign bus.rd1E        = r_ex_p1.rd1;
    assign bus.rd2E        = r_ex_p1.rd2;
    assign bus.immExtE     = r_ex_p1.immExt;
    assign bus.pcE         = r_ex_p1.pc;
    assign bus.pcPlus4E    = r_ex_p1.pcPlus4;
    assign bus.rs1E        = r_ex_p1.rs1;
    assign bus.rs2E        = r_ex_p1.rs2;
    assign bus.rdE         = r_ex_p1.rd;
    assign bus.validE      = r_ex_p1.valid;
    assign bus.stallF      = w_lwStall;
    assign bus.stallD      = w_lwStall;
    assign bus.flushD      = bus.pcSrcE;
    assign bus.bubbleCount = r_bubbleCount_p1;

endmodule
